// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a SPR_W x SPR_H ROM sprite into the framebuffer with colour-key
// transparency and right/bottom clipping; define SPRITE_FLIP_EN for flip_h/flip_v mirroring.
module sprite_blitter #(
   parameter int SPR_W = 8,
   parameter int SPR_H = 8,
   parameter int SCREEN_W = 320,
   parameter int SCREEN_H = 240,
   parameter int X_W = 9,
   parameter int Y_W = 8,
   parameter int FB_ADDR_W = 17,
   parameter int PIX_W = 24,
   parameter int ROM_D_W = 32,
   parameter int IMG_W = 8,
   parameter logic [PIX_W-1:0] TRANSP_KEY = 'hFF00FF
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     start,
   input  logic [X_W-1:0]                           x_pos,
   input  logic [Y_W-1:0]                           y_pos,
   input  logic [IMG_W-1:0]                         img_sel,
`ifdef SPRITE_FLIP_EN
   input  logic                                     flip_h,
   input  logic                                     flip_v,
`endif
   output logic                                     busy,
   output logic                                     done,
   output logic [IMG_W+$clog2(SPR_W*SPR_H)-1:0]     rom_addr,
   output logic                                     rom_rd_en,
   input  logic [ROM_D_W-1:0]                       rom_data,
   input  logic                                     rom_data_valid,
   output logic [FB_ADDR_W-1:0]                     frame_addr,
   output logic [PIX_W-1:0]                         frame_data,
   output logic                                     frame_we,
   input  logic                                     frame_write_valid
);
   localparam int CW = $clog2(SPR_W);
   localparam int RW = $clog2(SPR_H);

   typedef enum logic [1:0] {IDLE, READ, WRITE, NEXT} state_t;
   state_t state, state_n;

   logic [X_W-1:0]   x_lat;
   logic [Y_W-1:0]   y_lat;
   logic [IMG_W-1:0] img_lat;
   logic [CW-1:0]    col, rcol;
   logic [RW-1:0]    row, rrow;
   logic [X_W:0]     sx;
   logic [Y_W:0]     sy;
   logic             visible, last, rom_hi_unused;

`ifdef SPRITE_FLIP_EN
   logic fh_lat, fv_lat;
   // power-of-2 sizes make SPR_W-1-col a plain bitwise inversion
   assign rcol = fh_lat ? ~col : col;
   assign rrow = fv_lat ? ~row : row;
`else
   assign rcol = col;
   assign rrow = row;
`endif

   assign sx            = (X_W+1)'(x_lat) + (X_W+1)'(col);
   assign sy            = (Y_W+1)'(y_lat) + (Y_W+1)'(row);
   assign visible       = (32'(sx) < SCREEN_W) && (32'(sy) < SCREEN_H);
   assign last          = (&col) && (&row);
   assign rom_addr      = {img_lat, rrow, rcol};
   assign rom_rd_en     = state == READ;
   assign frame_we      = state == WRITE;
   assign frame_addr    = FB_ADDR_W'(32'(sy) * 32'(SCREEN_W) + 32'(sx));
   assign rom_hi_unused = ^rom_data;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start ? READ : IDLE;
         READ:    state_n = !rom_data_valid ? READ :
                            (rom_data[PIX_W-1:0] != TRANSP_KEY && visible) ? WRITE : NEXT;
         WRITE:   state_n = frame_write_valid ? NEXT : WRITE;
         default: state_n = last ? IDLE : READ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         x_lat      <= '0;
         y_lat      <= '0;
         img_lat    <= '0;
         col        <= '0;
         row        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         frame_data <= '0;
`ifdef SPRITE_FLIP_EN
         fh_lat     <= 1'b0;
         fv_lat     <= 1'b0;
`endif
      end else begin
         state <= state_n;
         if (state == IDLE && start) begin
            x_lat   <= x_pos;
            y_lat   <= y_pos;
            img_lat <= img_sel;
            col     <= '0;
            row     <= '0;
            done    <= 1'b0;
            busy    <= 1'b1;
`ifdef SPRITE_FLIP_EN
            fh_lat  <= flip_h;
            fv_lat  <= flip_v;
`endif
         end
         if (state == READ && rom_data_valid)
            frame_data <= rom_data[PIX_W-1:0];
         // counters wrap to zero naturally on the final pixel
         if (state == NEXT) begin
            col <= col + CW'(1);
            if (&col)
               row <= row + RW'(1);
            if (last) begin
               done <= 1'b1;
               busy <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: randomized bench for sprite_blitter with a raster-level reference model
// and ROM/framebuffer responders that insert random wait states.
module tb_sprite_blitter;
   localparam logic [23:0] KEY = 24'hFF00FF;

   logic        clk = 0, rst = 1, start = 0;
   logic [8:0]  x_pos = 0;
   logic [7:0]  y_pos = 0, img_sel = 0;
   logic        busy, done, rom_rd_en, frame_we;
   logic        rom_data_valid = 0, frame_write_valid = 0;
   logic [13:0] rom_addr;
   logic [31:0] rom_data = 0;
   logic [16:0] frame_addr;
   logic [23:0] frame_data;
`ifdef SPRITE_FLIP_EN
   logic        flip_h = 0, flip_v = 0;
`endif

   logic [23:0] rom_mem [0:16383];
   logic [40:0] got_q[$], exp_q[$], basic_q[$];
   logic [13:0] raddr_q[$];
   int          n_checks = 0, n_fail = 0, max_wait = 0;
   bit          rom_pend = 0, rom_given = 0, fb_pend = 0, fb_given = 0;
   int          rom_left = 0, fb_left = 0;
   logic [13:0] rom_hold;
   logic [40:0] fb_hold;

   always #5 clk = ~clk;

   sprite_blitter dut (
      .clk(clk), .rst(rst), .start(start), .x_pos(x_pos), .y_pos(y_pos), .img_sel(img_sel),
`ifdef SPRITE_FLIP_EN
      .flip_h(flip_h), .flip_v(flip_v),
`endif
      .busy(busy), .done(done), .rom_addr(rom_addr), .rom_rd_en(rom_rd_en),
      .rom_data(rom_data), .rom_data_valid(rom_data_valid),
      .frame_addr(frame_addr), .frame_data(frame_data), .frame_we(frame_we),
      .frame_write_valid(frame_write_valid)
   );

   // sprite ROM responder: random latency, request must stay stable until served
   always @(negedge clk) begin
      rom_data_valid = 0;
      rom_data = $urandom;
      if (rst) rom_pend = 0;
      else if (!rom_rd_en) begin
         if (rom_pend) begin
            n_checks++;
            if (!rom_given) begin n_fail++; $display("FAIL rom_rd_en_held: dropped=1 required=0"); end
         end
         rom_pend = 0;
         if (max_wait > 0) rom_data_valid = 1'($urandom_range(0, 1));
      end else begin
         if (!rom_pend) begin
            rom_pend = 1; rom_given = 0; rom_hold = rom_addr;
            rom_left = $urandom_range(0, max_wait);
         end else begin
            n_checks++;
            if (rom_addr !== rom_hold) begin
               n_fail++; $display("FAIL rom_addr_stable: got %0d required %0d", rom_addr, rom_hold);
            end
         end
         if (rom_left == 0) begin
            rom_data_valid = 1; rom_given = 1;
            rom_data = {8'($urandom), rom_mem[rom_addr]};
            raddr_q.push_back(rom_addr);
         end else rom_left--;
      end
   end

   // framebuffer responder: records every accepted write as {addr,data}
   always @(negedge clk) begin
      frame_write_valid = 0;
      if (rst) fb_pend = 0;
      else if (!frame_we) begin
         if (fb_pend) begin
            n_checks++;
            if (!fb_given) begin n_fail++; $display("FAIL frame_we_held: dropped=1 required=0"); end
         end
         fb_pend = 0;
         if (max_wait > 0) frame_write_valid = 1'($urandom_range(0, 1));
      end else begin
         if (!fb_pend) begin
            fb_pend = 1; fb_given = 0; fb_hold = {frame_addr, frame_data};
            fb_left = $urandom_range(0, max_wait);
         end else begin
            n_checks++;
            if ({frame_addr, frame_data} !== fb_hold) begin
               n_fail++; $display("FAIL frame_stable: got %h required %h", {frame_addr, frame_data}, fb_hold);
            end
         end
         if (fb_left == 0) begin
            frame_write_valid = 1; fb_given = 1;
            got_q.push_back({frame_addr, frame_data});
         end else fb_left--;
      end
   end

   // reference: raster walk over the sprite, returns zero-wait completion cycle
   function automatic int build_exp(int x, int y, int img, bit fh, bit fv);
      int cyc = 0;
      exp_q.delete();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            logic [23:0] p = rom_mem[img*64 + (fv ? 7-r : r)*8 + (fh ? 7-c : c)];
            if (p != KEY && x + c < 320 && y + r < 240) begin
               exp_q.push_back({17'((y+r)*320 + x + c), p});
               cyc += 3;
            end else cyc += 2;
         end
      return cyc;
   endfunction

   task automatic fill_img(input int img);
      for (int i = 0; i < 64; i++) begin
         logic [23:0] v = 24'($urandom);
         rom_mem[img*64 + i] = (v == KEY) ? v ^ 24'h1 : v;
      end
   endtask

   task automatic run_draw(input int x, input int y, input int img, input bit fh, input bit fv,
                           input string tag, output int cyc);
      bit busy_bad = 0;
      got_q.delete(); raddr_q.delete();
      @(negedge clk);
      x_pos = 9'(x); y_pos = 8'(y); img_sel = 8'(img); start = 1;
`ifdef SPRITE_FLIP_EN
      flip_h = fh; flip_v = fv;
`endif
      @(posedge clk); @(negedge clk); start = 0;
      n_checks++;
      if (busy !== 1 || done !== 0) begin
         n_fail++; $display("FAIL %s_start_flags: busy=%b done=%b required busy=1 done=0", tag, busy, done);
      end
      cyc = 0;
      for (int i = 1; i <= 5000 && !done; i++) begin
         @(negedge clk);
         cyc = i;
         if (!done && busy !== 1) busy_bad = 1;
      end
      n_checks++;
      if (done !== 1 || busy !== 0 || busy_bad) begin
         n_fail++; $display("FAIL %s_completion: done=%b busy=%b busy_gap=%0d after %0d cycles, required done=1 busy=0 gap=0", tag, done, busy, busy_bad, cyc);
      end
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL %s_write_count: got %0d required %0d", tag, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL %s_write[%0d]: got %h required %h", tag, i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      n_checks++;
      if ({busy, done, rom_rd_en, frame_we} !== 4'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b required 0000", {busy, done, rom_rd_en, frame_we});
      end
      n_checks++;
      if (rom_addr !== 0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d required 0", rom_addr); end
      n_checks++;
      if (frame_addr !== 0) begin n_fail++; $display("FAIL reset_frame_addr: got %0d required 0", frame_addr); end
      n_checks++;
      if (frame_data !== 0) begin n_fail++; $display("FAIL reset_frame_data: got %h required 0", frame_data); end
   endtask

   task automatic test_basic();
      int cyc;
      max_wait = 0;
      fill_img(3);
      void'(build_exp(10, 20, 3, 0, 0));
      run_draw(10, 20, 3, 0, 0, "basic", cyc);
      basic_q = got_q;
      n_checks++;
      if (cyc != 192) begin n_fail++; $display("FAIL basic_latency: got %0d required 192", cyc); end
      n_checks++;
      if (got_q.size() != 64) begin n_fail++; $display("FAIL basic_count: got %0d required 64", got_q.size()); end
      n_checks++;
      if (got_q.size() == 0 || got_q[0][40:24] !== 17'd6410) begin
         n_fail++; $display("FAIL basic_first_addr: got %0d required 6410", got_q.size() ? got_q[0][40:24] : 0);
      end
      n_checks++;
      if (raddr_q.size() != 64) begin n_fail++; $display("FAIL basic_rom_reads: got %0d required 64", raddr_q.size()); end
      for (int i = 0; i < raddr_q.size(); i++) begin
         n_checks++;
         if (raddr_q[i] !== 14'(192 + i)) begin
            n_fail++; $display("FAIL basic_rom_addr[%0d]: got %0d required %0d", i, raddr_q[i], 192 + i);
         end
      end
   endtask

   task automatic test_waits();
      int cyc;
      max_wait = 3;
      void'(build_exp(10, 20, 3, 0, 0));
      run_draw(10, 20, 3, 0, 0, "waits", cyc);
      n_checks++;
      if (got_q != basic_q) begin
         n_fail++; $display("FAIL waits_vs_zero_wait: got %0d writes required identical %0d", got_q.size(), basic_q.size());
      end
      max_wait = 0;
   endtask

   task automatic test_transparent();
      int cyc, exp_cyc, x, y, keyed;
      logic [16:0] key_addr[$];
      x = $urandom_range(0, 312); y = $urandom_range(0, 232);
      fill_img(5);
      keyed = 0;
      while (keyed < 10) begin
         int k = $urandom_range(0, 63);
         if (rom_mem[5*64 + k] != KEY) begin
            rom_mem[5*64 + k] = KEY;
            key_addr.push_back(17'((y + k/8)*320 + x + k%8));
            keyed++;
         end
      end
      exp_cyc = build_exp(x, y, 5, 0, 0);
      run_draw(x, y, 5, 0, 0, "transp", cyc);
      n_checks++;
      if (got_q.size() != 54) begin n_fail++; $display("FAIL transp_count: got %0d required 54", got_q.size()); end
      n_checks++;
      if (cyc != 182 || cyc != exp_cyc) begin n_fail++; $display("FAIL transp_latency: got %0d required 182", cyc); end
      foreach (got_q[i])
         foreach (key_addr[j]) begin
            n_checks++;
            if (got_q[i][40:24] === key_addr[j]) begin
               n_fail++; $display("FAIL transp_keyed_written: addr %0d written required none", key_addr[j]);
            end
         end
   endtask

   task automatic test_clip();
      int cyc, img;
      img = $urandom_range(10, 60);
      fill_img(img);
      void'(build_exp(316, 236, img, 0, 0));
      run_draw(316, 236, img, 0, 0, "clip", cyc);
      n_checks++;
      if (got_q.size() != 16) begin n_fail++; $display("FAIL clip_count: got %0d required 16", got_q.size()); end
      n_checks++;
      if (got_q.size() == 0 || got_q[$][40:24] !== 17'd76799) begin
         n_fail++; $display("FAIL clip_last_addr: got %0d required 76799", got_q.size() ? got_q[$][40:24] : 0);
      end
      n_checks++;
      if (cyc != 144) begin n_fail++; $display("FAIL clip_latency: got %0d required 144", cyc); end
   endtask

   task automatic test_random();
      int cyc, x, y, img;
      for (int t = 0; t < 5; t++) begin
         img = $urandom_range(0, 255);
         fill_img(img);
         for (int i = 0; i < 64; i++) if ($urandom_range(0, 7) == 0) rom_mem[img*64 + i] = KEY;
         x = (t == 0) ? 400 : $urandom_range(0, 511);
         y = (t == 0) ? 250 : $urandom_range(0, 255);
         max_wait = (t == 0) ? 0 : $urandom_range(0, 3);
         void'(build_exp(x, y, img, 0, 0));
         run_draw(x, y, img, 0, 0, "random", cyc);
         if (t == 0) begin
            n_checks++;
            if (got_q.size() != 0 || cyc != 128) begin
               n_fail++; $display("FAIL offscreen: writes=%0d cycles=%0d required writes=0 cycles=128", got_q.size(), cyc);
            end
         end
      end
      max_wait = 0;
   endtask

   task automatic test_restart_reset();
      bit leak = 0;
      max_wait = 0;
      got_q.delete();
      void'(build_exp(10, 20, 3, 0, 0));
      @(negedge clk);
      x_pos = 10; y_pos = 20; img_sel = 3; start = 1;
      @(negedge clk); start = 0;
      for (int i = 0; i < 500 && got_q.size() < 5; i++) @(negedge clk);
      x_pos = 100; y_pos = 100; img_sel = 9; start = 1;
      @(negedge clk); start = 0;
      for (int i = 0; i < 2000 && got_q.size() < 30; i++) @(negedge clk);
      @(posedge clk); #1 rst = 1;
      @(negedge clk);
      n_checks++;
      if ({busy, done, rom_rd_en, frame_we} !== 4'b0 || rom_addr !== 0 || frame_addr !== 0 || frame_data !== 0) begin
         n_fail++; $display("FAIL abort_outputs: flags=%b rom_addr=%0d frame_addr=%0d frame_data=%h required all 0",
                            {busy, done, rom_rd_en, frame_we}, rom_addr, frame_addr, frame_data);
      end
      @(negedge clk); rst = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (frame_we || rom_rd_en || busy) leak = 1;
      end
      n_checks++;
      if (leak) begin n_fail++; $display("FAIL abort_idle: activity=1 required 0"); end
      n_checks++;
      if (got_q.size() != 30) begin n_fail++; $display("FAIL abort_count: got %0d required 30", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 30; i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL abort_prefix[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

`ifdef SPRITE_FLIP_EN
   task automatic test_flip();
      int cyc;
      fill_img(9);
      void'(build_exp(50, 60, 9, 1, 0));
      run_draw(50, 60, 9, 1, 0, "flip_h", cyc);
      n_checks++;
      if (got_q.size() == 0 || got_q[0] !== {17'(60*320 + 50), rom_mem[9*64 + 7]}) begin
         n_fail++; $display("FAIL flip_h_first: got %h required %h", got_q.size() ? got_q[0] : 41'h0, {17'(60*320 + 50), rom_mem[9*64 + 7]});
      end
      void'(build_exp(50, 60, 9, 0, 1));
      run_draw(50, 60, 9, 0, 1, "flip_v", cyc);
      n_checks++;
      if (got_q.size() == 0 || got_q[0] !== {17'(60*320 + 50), rom_mem[9*64 + 56]}) begin
         n_fail++; $display("FAIL flip_v_first: got %h required %h", got_q.size() ? got_q[0] : 41'h0, {17'(60*320 + 50), rom_mem[9*64 + 56]});
      end
   endtask
`endif

   task automatic test_back_to_back();
      int cyc;
      void'(build_exp(10, 20, 3, 0, 0));
      run_draw(10, 20, 3, 0, 0, "after_abort", cyc);
      n_checks++;
      if (cyc != 192) begin n_fail++; $display("FAIL after_abort_latency: got %0d required 192", cyc); end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) rom_mem[i] = 24'h000001;
      test_reset();
      test_basic();
      test_waits();
      test_transparent();
      test_clip();
      test_random();
      test_restart_reset();
`ifdef SPRITE_FLIP_EN
      test_flip();
`endif
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
